key_irq_ctrl: RTL and testbench

//  Parametrised key/switch input controller on the MIPS external-device bus.

---
 rtl/key_irq_ctrl.sv | 116 +++++++++++
 tb/tb_key_irq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_irq_ctrl.sv
// Key/switch input controller: synchronised, optionally debounced key levels with sticky
// write-1-to-clear change flags and a maskable level IRQ. Define KEY_DEBOUNCE_EN for debounce.
module key_irq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Keys,
  input  logic [1:0]       Addr,
  input  logic             We,
  input  logic [31:0]      Wd,
  output logic [31:0]      Rd,
  output logic             IRQ
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_mask;
  logic             r_irq;

  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_pend_clr;
  logic [WIDTH-1:0] w_pend_next;
  logic [WIDTH-1:0] w_mask_next;
  logic             w_unused_wd;

  // Upper write-data bits are meaningless when WIDTH < 32.
  assign w_unused_wd = ^Wd;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= Keys;
      r_sync2 <= r_sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_next;

  // A bit is accepted only after differing from DATA for DEB_CYCLES consecutive cycles.
  always_comb begin
    w_data_next = r_data;
    w_chg       = '0;
    w_cnt_next  = r_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_data[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_cnt_next[i]  = '0;
        w_data_next[i] = r_sync2[i];
        w_chg[i]       = 1'b1;
      end else begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  assign w_data_next = r_sync2;
  assign w_chg       = r_sync2 ^ r_data;
`endif

  // Set from a change event wins over a same-cycle W1C clear.
  assign w_pend_clr  = (We && (Addr == A_PEND)) ? Wd[WIDTH-1:0] : '0;
  assign w_pend_next = w_chg | (r_pend & ~w_pend_clr);
  assign w_mask_next = (We && (Addr == A_MASK)) ? Wd[WIDTH-1:0] : r_mask;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_data <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_data <= w_data_next;
      r_pend <= w_pend_next;
      r_mask <= w_mask_next;
      r_irq  <= |(w_pend_next & w_mask_next);
    end
  end

  always_comb begin
    Rd = 32'b0;
    case (Addr)
      A_DATA:  Rd = 32'(r_data);
      A_PEND:  Rd = 32'(r_pend);
      A_MASK:  Rd = 32'(r_mask);
      default: Rd = 32'b0;
    endcase
  end

  assign IRQ = r_irq;

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Bench for key_irq_ctrl: directed scenarios plus random traffic, scored against a
// history-window reference model through an expectation queue.
module tb_key_irq_ctrl;
  localparam int WIDTH = 8;
  localparam int DEB   = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  keys  = '0;
  logic [1:0]  addr  = '0;
  logic        we    = 1'b0;
  logic [31:0] wd    = '0;
  logic [31:0] rd;
  logic        irq;

  key_irq_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .Clk(clk), .Reset(rst_n), .Keys(keys), .Addr(addr),
    .We(we), .Wd(wd), .Rd(rd), .IRQ(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          cyc;
    logic [1:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state
  logic [7:0] m_data, m_pend, m_mask;
  logic       m_irq;
  logic [7:0] ksamp[$];
  logic [7:0] shist[$];

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_data};
      2'd1:    return {24'b0, m_pend};
      2'd2:    return {24'b0, m_mask};
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = '0; m_pend = '0; m_mask = '0; m_irq = 1'b0;
    ksamp.delete();
    shist.delete();
  endtask

  // One rising edge of the model, using the inputs presented before the edge.
  task automatic m_edge();
    logic [7:0] s, chg, clr;
    int run;
    s = (ksamp.size() >= 2) ? ksamp[ksamp.size()-2] : 8'h00;
    ksamp.push_back(keys);
    shist.push_back(s);
    if (ksamp.size() > 8) void'(ksamp.pop_front());
    if (shist.size() > 4*DEB) void'(shist.pop_front());
`ifdef KEY_DEBOUNCE_EN
    chg = '0;
    for (int b = 0; b < WIDTH; b++) begin
      run = 0;
      for (int k = 1; k <= DEB && k <= shist.size(); k++) begin
        if (shist[shist.size()-k][b] != m_data[b]) run++;
        else break;
      end
      if (run == DEB) chg[b] = 1'b1;
    end
    m_data = m_data ^ chg;
`else
    chg    = s ^ m_data;
    m_data = s;
`endif
    clr    = (we && addr == 2'd1) ? wd[7:0] : 8'h00;
    m_pend = chg | (m_pend & ~clr);
    if (we && addr == 2'd2) m_mask = wd[7:0];
    m_irq  = |(m_pend & m_mask);
  endtask

  // Drive one cycle: present inputs, queue the expected outputs, advance one edge.
  task automatic step(input logic [7:0] k, input logic [1:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    keys = k; addr = a; we = w; wd = d;
    e.rd = m_rd(a); e.irq = m_irq; e.cyc = cyc; e.addr = a;
    sb.push_back(e);
    @(posedge clk);
    if (rst_n) m_edge();
    cyc++;
    #1;
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, 2'(i % 4), 1'b0, 32'h0);
  endtask

  task automatic do_reset(input logic [7:0] k);
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) step(k, 2'(i), 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rd !== e.rd) begin
        bad++;
        $display("FAIL rd cyc=%0d addr=%0d got=%h exp=%h", e.cyc, e.addr, rd, e.rd);
      end
      total++;
      if (irq !== e.irq) begin
        bad++;
        $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, irq, e.irq);
      end
    end
  end

  initial begin
    logic [7:0] k;
    m_reset();
    @(posedge clk); #1;
    do_reset(8'h00);

    // Reset mid-run with keys high, then recovery
    hold(8'h3C, 24);
    do_reset(8'hFF);
    hold(8'hFF, 22);

    // Masked bit 0 raises IRQ, W1C clears it
    do_reset(8'h00);
    step(8'h00, 2'd2, 1'b1, 32'h01);
    hold(8'h01, 22);
    step(8'h01, 2'd1, 1'b1, 32'h01);
    hold(8'h01, 4);

    // Short pulse filtered, long pulse accepted
    do_reset(8'h00);
    step(8'h00, 2'd2, 1'b1, 32'hFF);
    hold(8'h08, 15);
    hold(8'h00, 20);
    hold(8'h08, 22);

    // Pending while masked, unmask raises IRQ, zero W1C is a no-op
    do_reset(8'h00);
    step(8'h00, 2'd2, 1'b1, 32'h00);
    hold(8'h10, 22);
    step(8'h10, 2'd2, 1'b1, 32'hFF);
    step(8'h10, 2'd1, 1'b1, 32'h00);
    hold(8'h10, 4);

    // W1C on bit 2 every cycle while its change is accepted
    do_reset(8'h00);
    step(8'h00, 2'd2, 1'b1, 32'h04);
    for (int i = 0; i < 24; i++) step(8'h04, 2'd1, 1'b1, 32'h04);
    hold(8'h04, 4);

    // Multi-bit change, unmapped reads, writes to DATA and Addr 3 ignored
    do_reset(8'h00);
    hold(8'hA5, 22);
    step(8'hA5, 2'd0, 1'b1, 32'hFFFF_FFFF);
    step(8'hA5, 2'd3, 1'b1, 32'hFFFF_FFFF);
    hold(8'hA5, 4);

    // Random traffic
    k = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(k);
      if ($urandom_range(0, 23) == 0) k = 8'($urandom);
      step(k, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom);
    end
    hold(k, 4);

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
